// File: rtl/csr_trap_sequencer_pkg.sv
// Shared CSR addresses, mstatus bit positions and sequencer state encodings.
package csr_trap_sequencer_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_T_MEPC    = 3'd1,
    ST_T_MCAUSE  = 3'd2,
    ST_T_MTVAL   = 3'd3,
    ST_T_MSTATUS = 3'd4,
    ST_M_MSTATUS = 3'd5,
    ST_REDIRECT  = 3'd6
  } state_e;

endpackage

// File: rtl/csr_mstatus_update.sv
// Combinational mstatus rewrite for machine-mode trap entry and MRET.
module csr_mstatus_update
  import csr_trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old_mstatus,
  input  logic            is_mret,
  output logic [XLEN-1:0] new_mstatus
);

  always_comb begin
    new_mstatus = old_mstatus;
    if (is_mret) begin
      new_mstatus[MSTATUS_MIE]                   = old_mstatus[MSTATUS_MPIE];
      new_mstatus[MSTATUS_MPIE]                  = 1'b1;
      new_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
    end else begin
      new_mstatus[MSTATUS_MPIE]                  = old_mstatus[MSTATUS_MIE];
      new_mstatus[MSTATUS_MIE]                   = 1'b0;
      new_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Owns the CSR write port: forwards pipeline writes, sequences trap entry and MRET.
// Optional macro CSR_VECTORED_EN enables vectored interrupt redirect via mtvec mode.
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_req,
  input  logic [XLEN-1:0]       trap_cause,
  input  logic [XLEN-1:0]       trap_pc,
  input  logic [XLEN-1:0]       trap_tval,
  input  logic                  mret_req,
  input  logic                  pipe_wr_en,
  input  logic [CSR_ADDR_W-1:0] pipe_wr_addr,
  input  logic [XLEN-1:0]       pipe_wr_data,
  input  logic [XLEN-1:0]       mstatus_in,
  input  logic [XLEN-1:0]       mtvec_in,
  input  logic [XLEN-1:0]       mepc_in,
  output logic                  csr_wr_en,
  output logic [CSR_ADDR_W-1:0] csr_wr_addr,
  output logic [XLEN-1:0]       csr_wr_data,
  output logic                  halt,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [XLEN-1:0]       cause_q, cause_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic [XLEN-1:0]       tval_q, tval_d;
  logic [XLEN-1:0]       mstatus_q, mstatus_d;
  logic [XLEN-1:0]       mtvec_q, mtvec_d;
  logic [XLEN-1:0]       mepc_q, mepc_d;
  logic                  is_mret_q, is_mret_d;

  logic                  csr_wr_en_q, csr_wr_en_d;
  logic [CSR_ADDR_W-1:0] csr_wr_addr_q, csr_wr_addr_d;
  logic [XLEN-1:0]       csr_wr_data_q, csr_wr_data_d;
  logic                  halt_q, halt_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]       redirect_pc_q, redirect_pc_d;
  logic                  busy_q, busy_d;

  logic                  upd_mret;
  logic [XLEN-1:0]       upd_old;
  logic [XLEN-1:0]       upd_new;
  logic [XLEN-1:0]       trap_target;

  // MRET reads mstatus live in its only state; trap entry uses the copy sampled in T_MTVAL.
  assign upd_mret = (state_q == ST_M_MSTATUS);
  assign upd_old  = upd_mret ? mstatus_in : mstatus_q;

  csr_mstatus_update #(.XLEN(XLEN)) u_mstatus_update (
    .old_mstatus (upd_old),
    .is_mret     (upd_mret),
    .new_mstatus (upd_new)
  );

`ifdef CSR_VECTORED_EN
  always_comb begin
    trap_target = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && cause_q[XLEN-1])
      trap_target = trap_target + {cause_q[XLEN-3:0], 2'b00};
  end
`else
  assign trap_target = mtvec_q;
`endif

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    pc_d             = pc_q;
    tval_d           = tval_q;
    mstatus_d        = mstatus_q;
    mtvec_d          = mtvec_q;
    mepc_d           = mepc_q;
    is_mret_d        = is_mret_q;
    csr_wr_en_d      = 1'b0;
    csr_wr_addr_d    = '0;
    csr_wr_data_d    = '0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (trap_req) begin
          state_d   = ST_T_MEPC;
          cause_d   = trap_cause;
          pc_d      = {trap_pc[XLEN-1:2], 2'b00};
          tval_d    = trap_tval;
          is_mret_d = 1'b0;
        end else if (mret_req) begin
          state_d   = ST_M_MSTATUS;
          is_mret_d = 1'b1;
        end else if (pipe_wr_en) begin
          csr_wr_en_d   = 1'b1;
          csr_wr_addr_d = pipe_wr_addr;
          csr_wr_data_d = pipe_wr_data;
        end
      end
      ST_T_MEPC: begin
        csr_wr_en_d   = 1'b1;
        csr_wr_addr_d = CSR_ADDR_W'(CSR_MEPC);
        csr_wr_data_d = pc_q;
        state_d       = ST_T_MCAUSE;
      end
      ST_T_MCAUSE: begin
        csr_wr_en_d   = 1'b1;
        csr_wr_addr_d = CSR_ADDR_W'(CSR_MCAUSE);
        csr_wr_data_d = cause_q;
        state_d       = ST_T_MTVAL;
      end
      ST_T_MTVAL: begin
        csr_wr_en_d   = 1'b1;
        csr_wr_addr_d = CSR_ADDR_W'(CSR_MTVAL);
        csr_wr_data_d = tval_q;
        mstatus_d     = mstatus_in;
        state_d       = ST_T_MSTATUS;
      end
      ST_T_MSTATUS: begin
        csr_wr_en_d   = 1'b1;
        csr_wr_addr_d = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wr_data_d = upd_new;
`ifdef CSR_VECTORED_EN
        mtvec_d       = mtvec_in;
`else
        mtvec_d       = {mtvec_in[XLEN-1:2], 2'b00};
`endif
        state_d       = ST_REDIRECT;
      end
      ST_M_MSTATUS: begin
        csr_wr_en_d   = 1'b1;
        csr_wr_addr_d = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wr_data_d = upd_new;
        mstatus_d     = mstatus_in;
        mepc_d        = mepc_in;
        state_d       = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = is_mret_q ? mepc_q : trap_target;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Stall stays up through the cycle that presents the redirect.
    halt_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cause_q          <= '0;
      pc_q             <= '0;
      tval_q           <= '0;
      mstatus_q        <= '0;
      mtvec_q          <= '0;
      mepc_q           <= '0;
      is_mret_q        <= 1'b0;
      csr_wr_en_q      <= 1'b0;
      csr_wr_addr_q    <= '0;
      csr_wr_data_q    <= '0;
      halt_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cause_q          <= cause_d;
      pc_q             <= pc_d;
      tval_q           <= tval_d;
      mstatus_q        <= mstatus_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      is_mret_q        <= is_mret_d;
      csr_wr_en_q      <= csr_wr_en_d;
      csr_wr_addr_q    <= csr_wr_addr_d;
      csr_wr_data_q    <= csr_wr_data_d;
      halt_q           <= halt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign csr_wr_en      = csr_wr_en_q;
  assign csr_wr_addr    = csr_wr_addr_q;
  assign csr_wr_data    = csr_wr_data_q;
  assign halt           = halt_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed self-checking bench for csr_trap_sequencer: reset, pipe forwarding, trap, MRET, collisions.
module tb_csr_trap_sequencer;

  logic        clk;
  logic        rst;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_req;
  logic        pipe_wr_en;
  logic [11:0] pipe_wr_addr;
  logic [31:0] pipe_wr_data;
  logic [31:0] mstatus_in;
  logic [31:0] mtvec_in;
  logic [31:0] mepc_in;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int compareCount;
  int mismatchCount;

  csr_trap_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .trap_req       (trap_req),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .trap_tval      (trap_tval),
    .mret_req       (mret_req),
    .pipe_wr_en     (pipe_wr_en),
    .pipe_wr_addr   (pipe_wr_addr),
    .pipe_wr_data   (pipe_wr_data),
    .mstatus_in     (mstatus_in),
    .mtvec_in       (mtvec_in),
    .mepc_in        (mepc_in),
    .csr_wr_en      (csr_wr_en),
    .csr_wr_addr    (csr_wr_addr),
    .csr_wr_data    (csr_wr_data),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Observation point is 1 ns after the rising edge, well clear of it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkCycle(input string tag, input logic en, input logic [11:0] addr,
                            input logic [31:0] data, input logic hlt, input logic rv,
                            input logic [31:0] rpc, input logic bsy);
    checkOutput({tag, ".wr_en"},   {31'd0, csr_wr_en},      {31'd0, en});
    checkOutput({tag, ".wr_addr"}, {20'd0, csr_wr_addr},    {20'd0, addr});
    checkOutput({tag, ".wr_data"}, csr_wr_data,             data);
    checkOutput({tag, ".halt"},    {31'd0, halt},           {31'd0, hlt});
    checkOutput({tag, ".rv"},      {31'd0, redirect_valid}, {31'd0, rv});
    checkOutput({tag, ".rpc"},     redirect_pc,             rpc);
    checkOutput({tag, ".busy"},    {31'd0, busy},           {31'd0, bsy});
  endtask

  task automatic applyStimulus(input logic tr, input logic [31:0] cause, input logic [31:0] pc,
                               input logic [31:0] tval, input logic mr, input logic pw,
                               input logic [11:0] paddr, input logic [31:0] pdata);
    trap_req     = tr;
    trap_cause   = cause;
    trap_pc      = pc;
    trap_tval    = tval;
    mret_req     = mr;
    pipe_wr_en   = pw;
    pipe_wr_addr = paddr;
    pipe_wr_data = pdata;
  endtask

  task automatic clearRequests();
    trap_req   = 1'b0;
    mret_req   = 1'b0;
    pipe_wr_en = 1'b0;
  endtask

  // Full trap sequence with hand-computed expectations for cycles 1..7.
  task automatic runTrap(input string tag, input logic [31:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input logic [31:0] expMepc,
                         input logic [31:0] expMstatus, input logic [31:0] expRpc,
                         input logic withMret, input logic withPipe, input logic injectMid);
    applyStimulus(1'b1, cause, pc, tval, withMret, withPipe, 12'h340, 32'h1234_5678);
    tick();
    clearRequests();
    checkCycle({tag, ".c1"}, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkCycle({tag, ".c2"}, 1'b1, 12'h341, expMepc, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkCycle({tag, ".c3"}, 1'b1, 12'h342, cause, 1'b1, 1'b0, 32'h0, 1'b1);
    if (injectMid) begin
      applyStimulus(1'b1, 32'h0000_000B, 32'h0000_0F00, 32'h0000_0099, 1'b1, 1'b1, 12'h340, 32'hCAFE_F00D);
    end
    tick();
    clearRequests();
    checkCycle({tag, ".c4"}, 1'b1, 12'h343, tval, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkCycle({tag, ".c5"}, 1'b1, 12'h300, expMstatus, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkCycle({tag, ".c6"}, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, expRpc, 1'b0);
    tick();
    checkCycle({tag, ".c7"}, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] vecExpected;
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    mstatus_in = 32'h0000_0008;
    mtvec_in   = 32'h0000_0201;
    mepc_in    = 32'h0000_0400;
    #12;
    checkCycle("reset", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    tick();
    checkCycle("idle", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("[TB] pipe write forwarding");
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 12'h340, 32'hDEAD_BEEF);
    tick();
    clearRequests();
    checkCycle("pipe.c1", 1'b1, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checkCycle("pipe.c2", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("[TB] trap entry");
    runTrap("trap", 32'h0000_0002, 32'h0000_0103, 32'h0000_0055, 32'h0000_0100,
            32'h0000_1880, 32'h0000_0200, 1'b0, 1'b0, 1'b0);

    $display("[TB] interrupt cause");
`ifdef CSR_VECTORED_EN
    vecExpected = 32'h0000_021C;
`else
    vecExpected = 32'h0000_0200;
`endif
    runTrap("vec", 32'h8000_0007, 32'h0000_2000, 32'h0000_0000, 32'h0000_2000,
            32'h0000_1880, vecExpected, 1'b0, 1'b0, 1'b0);

    $display("[TB] mret");
    mstatus_in = 32'h0000_1880;
    mepc_in    = 32'h0000_0400;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 12'h000, 32'h0);
    tick();
    clearRequests();
    checkCycle("mret.c1", 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkCycle("mret.c2", 1'b1, 12'h300, 32'h0000_0088, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkCycle("mret.c3", 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 32'h0000_0400, 1'b0);
    tick();
    checkCycle("mret.c4", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("[TB] collision: trap + mret + pipe");
    mstatus_in = 32'h0000_0000;
    mtvec_in   = 32'h0000_1000;
    runTrap("coll", 32'h0000_0005, 32'h0000_0302, 32'h0000_0AAA, 32'h0000_0300,
            32'h0000_1800, 32'h0000_1000, 1'b1, 1'b1, 1'b0);

    $display("[TB] trap_req during T_MTVAL ignored");
    mstatus_in = 32'h0000_0088;
    mtvec_in   = 32'h0000_0804;
    runTrap("ign", 32'h0000_000C, 32'h0000_0510, 32'h0000_0123, 32'h0000_0510,
            32'h0000_1880, 32'h0000_0804, 1'b0, 1'b0, 1'b1);

    $display("[TB] reset mid-sequence");
    mstatus_in = 32'h0000_0008;
    mtvec_in   = 32'h0000_0201;
    applyStimulus(1'b1, 32'h0000_0002, 32'h0000_0103, 32'h0000_0055, 1'b0, 1'b0, 12'h000, 32'h0);
    tick();
    clearRequests();
    tick();
    checkCycle("rstmid.pre", 1'b1, 12'h341, 32'h0000_0100, 1'b1, 1'b0, 32'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkCycle("rstmid.async", 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkOutput("rstmid.rv", {31'd0, redirect_valid}, 32'h0);
      checkOutput("rstmid.busy", {31'd0, busy}, 32'h0);
      checkOutput("rstmid.wr_en", {31'd0, csr_wr_en}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/csr_trap_sequencer.md
Name: csr_trap_sequencer

Overview:
- Single owner of the CSR file write port.
- On a trap, it sequences the machine-mode trap-entry writes (mepc, mcause, mtval, mstatus) through that port, then issues a PC redirect. On MRET, it restores mstatus and redirects to mepc.
- When idle, it forwards ordinary pipeline CSR writes.
- Sits between the execute/writeback stage, the trap source and the CSR register file; halts the pipeline while sequencing.

Parameters:
- XLEN, 32, data/PC width
- CSR_ADDR_W, 12, CSR address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- trap_req  in  1  trap request, single-cycle pulse
- trap_cause  in  XLEN  mcause value; bit XLEN-1 = interrupt
- trap_pc  in  XLEN  PC of trapping instruction
- trap_tval  in  XLEN  mtval value
- mret_req  in  1  MRET retire pulse
- pipe_wr_en  in  1  pipeline CSR write request
- pipe_wr_addr  in  CSR_ADDR_W  pipeline CSR write address
- pipe_wr_data  in  XLEN  pipeline CSR write data
- mstatus_in  in  XLEN  current mstatus read value
- mtvec_in  in  XLEN  current mtvec read value
- mepc_in  in  XLEN  current mepc read value
- csr_wr_en  out  1  CSR file write enable
- csr_wr_addr  out  CSR_ADDR_W  CSR file write address
- csr_wr_data  out  XLEN  CSR file write data
- halt  out  1  pipeline stall
- redirect_valid  out  1  PC redirect strobe
- redirect_pc  out  XLEN  redirect target
- busy  out  1  FSM not IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high.
- Reset values: all outputs 0; FSM = IDLE; all capture registers 0. Reset mid-sequence abandons it with no partial redirect.
- Registered outputs: all outputs are registered, so each change appears one cycle after its cause.
- States: IDLE, T_MEPC, T_MCAUSE, T_MTVAL, T_MSTATUS, M_MSTATUS, REDIRECT.
- IDLE priority: trap_req > mret_req > pipe_wr_en.
  - trap_req: capture trap_cause/trap_pc/trap_tval; next state T_MEPC.
  - mret_req: next state M_MSTATUS.
  - pipe_wr_en alone: next cycle csr_wr_en=1 with pipe address/data; stay IDLE.
  - pipe_wr_en in the same cycle as trap_req or mret_req is dropped (the trapping/retiring instruction must not commit a CSR).
- Trap write sequence (one CSR write per state, output the cycle after state entry):
  - T_MEPC: addr 0x341, data trap_pc with bits[1:0] cleared.
  - T_MCAUSE: addr 0x342, data = captured cause.
  - T_MTVAL: addr 0x343, data = captured tval. Sample mstatus_in in this state.
  - T_MSTATUS: addr 0x300, data = sampled mstatus with MPIE(bit7) set to old MIE(bit3), MIE set to 0, MPP(bits12:11) set to 2'b11. Sample mtvec_in in this state.
  - REDIRECT: redirect_valid=1 for exactly one cycle, redirect_pc computed from the sampled mtvec; return to IDLE.
- MRET sequence:
  - M_MSTATUS: sample mstatus_in and mepc_in; write 0x300 with MIE set to MPIE, MPIE set to 1, MPP set to 2'b00.
  - REDIRECT: redirect_pc = sampled mepc.
- Latency: trap_req accepted at cycle 0 gives writes at cycles 2..5 and redirect_valid at cycle 6. MRET accepted at cycle 0 gives the mstatus write at cycle 2 and redirect at cycle 3.
- halt: 1 from cycle 1 through the redirect cycle inclusive.
- busy: equals (state != IDLE), registered.
- Ignored inputs: trap_req, mret_req and pipe_wr_en are ignored while not IDLE. The pipeline is halted then, so nothing is lost.
- Sampling: mstatus/mtvec/mepc are sampled late so any pipe write issued in the acceptance cycle has landed first.
- Base redirect target: mtvec with bits[1:0] cleared.

Optional Feature:
- Macro: CSR_VECTORED_EN.
- Defined: if mtvec[1:0]==2'b01 and the captured cause has bit XLEN-1 set, redirect_pc = base + 4*cause[XLEN-2:0] (mod 2^XLEN). Otherwise redirect_pc = base.
- Undefined: mtvec[1:0] is ignored; redirect_pc is always base.

Decomposition:
- Shared header: CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343), mstatus bit positions (MIE 3, MPIE 7, MPP 12:11), FSM state encodings.
- One natural sub-module: csr_mstatus_update, combinational. Inputs: old mstatus and a trap/mret select. Output: the new mstatus.

Test Plan:
- Reset: assert rst mid T_MCAUSE → all outputs 0 immediately; no redirect follows. Release → IDLE, busy=0.
- Pipe write: pipe_wr_en, addr 0x340, data 0xDEADBEEF in IDLE → next cycle csr_wr_en=1, addr 0x340, data 0xDEADBEEF; halt=0.
- Trap entry: trap_req, cause 0x2, pc 0x103, tval 0x55, mstatus_in 0x8, mtvec_in 0x201 → writes in order:
  - 0x341 ← 0x100
  - 0x342 ← 0x2
  - 0x343 ← 0x55
  - 0x300 ← 0x1880
  - then redirect_pc 0x200 at cycle 6; halt high for cycles 1..6.
- Vectored (CSR_VECTORED_EN): cause 0x80000007, mtvec 0x201 → redirect_pc 0x21C. Without the macro → 0x200.
- MRET: mstatus_in 0x1880, mepc_in 0x400 → write 0x300 ← 0x88, then redirect_pc 0x400 at cycle 3.
- Collisions and ignored requests:
  - trap_req + mret_req + pipe_wr_en in the same cycle → trap sequence only; pipe write never appears.
  - trap_req during T_MTVAL → ignored; sequence unchanged.
